// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder.
// Walks the digits LS first, blanks the anodes at each slot start, and snapshots inputs once per frame.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned BLANK_CYC  = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   digit_on,
  input  logic                    hex_mode,
  input  logic                    lz_supp,
  output logic [3:0]              dec_val,
  output logic                    dec_en,
  output logic                    dec_sel,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             cnt_wrap;
  logic             frame_wrap;

  // Frame snapshot registers; cap_pend forces a capture on the first edge out of reset
  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0]      on_r;
  logic                       mode_r;
  logic                       lz_r;
  logic                       cap_pend;

  logic [NUM_DIGITS-1:0] sup;
  logic                  zero_run;

  logic [NUM_DIGITS-1:0] an_nxt;
  logic                  dec_en_nxt;
  logic [3:0]            dec_val_nxt;
  logic                  dec_sel_nxt;
  logic                  frame_done_nxt;

  // Slot counter and digit index
  always_comb begin
    cnt_wrap   = (cnt == CNT_LAST);
    frame_wrap = cnt_wrap && (idx == IDX_LAST);
    cnt_nxt    = cnt_wrap ? '0 : cnt + CNT_W'(1);
    idx_nxt    = idx;
    if (cnt_wrap) begin
      idx_nxt = frame_wrap ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: the phase the upcoming counter value falls in
  always_comb begin
    state_nxt = ST_SHOW;
    if (cnt_nxt < BLANK_END) begin
      state_nxt = ST_BLANK;
    end
  end

  // Snapshot of inputs, taken at frame wrap so a frame never tears
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= '0;
      on_r     <= '0;
      mode_r   <= 1'b0;
      lz_r     <= 1'b0;
      cap_pend <= 1'b1;
    end else begin
      cap_pend <= 1'b0;
      if (cap_pend || frame_wrap) begin
        shadow <= digits;
        on_r   <= digit_on;
        mode_r <= hex_mode;
        lz_r   <= lz_supp;
      end
    end
  end

  // Leading-zero suppression: digit i dark when it and everything above it are zero
  always_comb begin
    zero_run = 1'b1;
    sup      = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run = zero_run & (shadow[i] == 4'h0);
      sup[i]   = lz_r & zero_run & (i != 0);
    end
  end

  // FSM output decode; the nibble is pre-loaded during blank
  always_comb begin
    an_nxt         = '1;
    dec_en_nxt     = 1'b0;
    dec_val_nxt    = shadow[idx];
    dec_sel_nxt    = mode_r;
    frame_done_nxt = frame_wrap;
    if ((state == ST_SHOW) && on_r[idx] && !sup[idx]) begin
      an_nxt[idx] = 1'b0;
      dec_en_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      dec_en     <= 1'b0;
      dec_val    <= 4'h0;
      dec_sel    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      dec_en     <= dec_en_nxt;
      dec_val    <= dec_val_nxt;
      dec_sel    <= dec_sel_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed + random bench for seg_scan_ctrl with a frame-position reference model and
// an expected-output queue popped one edge after each stimulus step.
module tb_seg_scan_ctrl;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 8;
  localparam int unsigned BC = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   digits;
  logic [3:0]    digit_on;
  logic          hex_mode;
  logic          lz_supp;
  logic [3:0]    dec_val;
  logic          dec_en;
  logic          dec_sel;
  logic [3:0]    an;
  logic          frame_done;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .digits(digits), .digit_on(digit_on),
    .hex_mode(hex_mode), .lz_supp(lz_supp), .dec_val(dec_val),
    .dec_en(dec_en), .dec_sel(dec_sel), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic       en;
    logic [3:0] val;
    logic       sel;
    logic       fd;
  } exp_t;

  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int last_fd = -1;

  // Reference model: position in frame counted from reset release
  int         t = 0;
  logic [15:0] m_sh = '0;
  logic [3:0]  m_on = '0;
  logic        m_mode = 1'b0;
  logic        m_lz = 1'b0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    int p;
    int ix;
    int h;
    logic was_rst;
    logic pop_ok;
    e.an  = 4'hF;
    e.en  = 1'b0;
    e.val = 4'h0;
    e.sel = 1'b0;
    e.fd  = 1'b0;
    if (!rst) begin
      p  = t % FRAME;
      ix = p / SD;
      h  = -1;
      for (int i = 0; i < ND; i++) begin
        if (m_sh[4*i +: 4] != 4'h0) h = i;
      end
      e.val = m_sh[4*ix +: 4];
      e.sel = m_mode;
      e.fd  = (p == FRAME - 1);
      if ((p % SD) >= BC && m_on[ix] && !(m_lz && ix != 0 && ix > h)) begin
        e.an[ix] = 1'b0;
        e.en     = 1'b1;
      end
    end
    q.push_back(e);
    @(posedge clk);
    was_rst = rst;
    if (rst) begin
      t = 0; m_sh = '0; m_on = '0; m_mode = 1'b0; m_lz = 1'b0;
    end else begin
      if (t == 0 || (t % FRAME) == FRAME - 1) begin
        m_sh = digits; m_on = digit_on; m_mode = hex_mode; m_lz = lz_supp;
      end
      t++;
    end
    #1;
    cyc++;
    g = q.pop_front();
    check("an", 8'(an), 8'(g.an));
    check("dec_en", 8'(dec_en), 8'(g.en));
    check("dec_val", 8'(dec_val), 8'(g.val));
    check("dec_sel", 8'(dec_sel), 8'(g.sel));
    check("frame_done", 8'(frame_done), 8'(g.fd));
    pop_ok = ($countones(~an) <= 1);
    check("one_hot_an", 8'(pop_ok), 8'd1);
    check("en_vs_an", 8'(dec_en), 8'(|(~an)));
    if (was_rst) begin
      last_fd = -1;
    end else if (frame_done === 1'b1) begin
      if (last_fd >= 0) check("fd_spacing", 8'(cyc - last_fd), 8'(FRAME));
      last_fd = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst = 1'b1; digits = 16'h4321; digit_on = 4'hF; hex_mode = 1'b0; lz_supp = 1'b0;
    #2;
    // Reset state
    run(2);
    rst = 1'b0;
    // Basic scan of 4321
    run(2 * FRAME);
    // Leading-zero suppression
    digits = 16'h0050; lz_supp = 1'b1;
    run(2 * FRAME);
    digits = 16'h0000;
    run(2 * FRAME);
    // Mid-frame change must not tear the frame
    digits = 16'h1111; lz_supp = 1'b0;
    run(FRAME + SD);
    digits = 16'h2222;
    run(2 * FRAME);
    // Per-digit enable with hex mode
    digit_on = 4'b0101; hex_mode = 1'b1; digits = 16'hABCD;
    run(2 * FRAME);
    // Reset during SHOW of digit 2
    for (int k = 0; k < FRAME && (t % FRAME) != 2 * SD + 4; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(FRAME + SD);
    // Random inputs with occasional reset
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        digits   = 16'($urandom());
        digit_on = 4'($urandom());
        hex_mode = 1'($urandom());
        lz_supp  = 1'($urandom());
      end
      if ($urandom_range(0, 3) == 0) digits[15:8] = 8'h00;
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
